a2d_arbiter: RTL



---
 rtl/a2d_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter among NREQ requesters.
// Per grant: latch channel, settle, pulse strt_cnv, await cnv_cmplt or timeout.
module a2d_arbiter #(
   parameter int unsigned NREQ    = 3,
   parameter int unsigned SETTLE  = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [3*NREQ-1:0]    req_chnnl,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      err,
   output logic [11:0]          res,
   output logic                 busy,
   output logic [2:0]           chnnl,
   output logic                 strt_cnv,
   input  logic                 cnv_cmplt,
   input  logic [11:0]          A2D_res
);

   localparam int unsigned SW = (SETTLE  > 1) ? $clog2(SETTLE)  : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned PW = (NREQ    > 1) ? $clog2(NREQ)    : 1;

   localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_START,
      ST_CONV,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t          r_state;
   logic [SW-1:0]   r_scnt;
   logic [TW-1:0]   r_tcnt;
   logic [PW-1:0]   r_ptr;

   logic            w_found;
   logic [PW-1:0]   w_win;
   logic [PW-1:0]   w_cand;
   logic [2:0]      w_chn;

   // Search starts one past the last winner and wraps, so the first hit is fair.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         w_cand = PW'((32'(r_ptr) + i) % NREQ);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
      w_chn = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_win == PW'(i)) w_chn = req_chnnl[3*i +: 3];
      end
   end

   assign busy = (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_scnt   <= '0;
         r_tcnt   <= '0;
         r_ptr    <= PW'(NREQ - 1);
         gnt      <= '0;
         done     <= '0;
         err      <= '0;
         res      <= '0;
         chnnl    <= '0;
         strt_cnv <= 1'b0;
      end else begin
         strt_cnv <= 1'b0;
         done     <= '0;
         err      <= '0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  gnt     <= NREQ'(1) << w_win;
                  chnnl   <= w_chn;
                  r_ptr   <= w_win;
                  r_scnt  <= '0;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_scnt == S_LAST) begin
                  strt_cnv <= 1'b1;
                  r_state  <= ST_START;
               end else begin
                  r_scnt <= r_scnt + 1'b1;
               end
            end
            ST_START: begin
               r_tcnt  <= '0;
               r_state <= ST_CONV;
            end
            ST_CONV: begin
               // Completion outranks a timeout landing in the same cycle.
               if (cnv_cmplt) begin
                  res     <= A2D_res;
                  done    <= gnt;
                  r_state <= ST_DONE;
               end else if (r_tcnt == T_LAST) begin
                  err     <= gnt;
                  r_state <= ST_ERR;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            ST_DONE, ST_ERR: begin
               gnt     <= '0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
